conv_engine: RTL and testbench
==============================

CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter LOG_W, default 6, meaning image side IMG_W = 2^LOG_W pixels, legal 2..6.
REQ-002 Parameter NUM_CH, default 2, meaning number of 3x3 kernels (output channels), legal 1..3.
REQ-003 Parameter DW, default 20, meaning signed data/weight width, fraction bits DW-4.
REQ-004 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 reset  in  1  async active-high reset.
REQ-007 ready  in  1  start request, sampled only while busy=0.
REQ-008 mode  in  1  0 = conv only, 1 = conv then 2x2 max-pool; sampled with ready.
REQ-009 kw  in  NUM_CH*9*DW  kernel weights, channel-major, tap index 3*dy+dx (dy,dx 0..2 map to offsets -1..+1); sampled with ready.
REQ-010 kb  in  NUM_CH*DW  per-channel bias; sampled with ready.
REQ-011 busy  out  1  high from start until job complete.
REQ-012 iaddr  out  2*LOG_W  image address row*IMG_W+col; idata valid the next cycle.
REQ-013 idata  in  DW  image pixel, signed.
REQ-014 cwr  out  1  result write strobe, single cycle.
REQ-015 caddr_wr  out  2*LOG_W  write address.
REQ-016 cdata_wr  out  DW  write data.
REQ-017 crd  out  1  read strobe for pool read-back; cdata_rd valid next cycle.
REQ-018 caddr_rd  out  2*LOG_W  read-back address.
REQ-019 cdata_rd  in  DW  read-back data.
REQ-020 csel  out  3  memory select: conv channel c -> 1+c; pool channel c -> 1+NUM_CH+c; 0 when idle.

Function
REQ-021 States IDLE, CONV_RD, CONV_ACC, CONV_WR, POOL_RD, POOL_CMP, POOL_WR; IDLE->CONV_RD the cycle after ready=1 sampled in IDLE; busy=1 in every non-IDLE state.
REQ-022 Conv order: pixels raster (row then col), per pixel channels 0..NUM_CH-1; image re-read per channel.
REQ-023 CONV_RD lasts exactly 9 cycles, one tap per cycle in tap order; out-of-image taps issue no new address, contribute 0 (zero padding).
REQ-024 MAC: DW x DW signed product, 2*DW+4-bit accumulator, no intermediate truncation; CONV_ACC (1 cycle) adds last product and bias shifted left DW-4.
REQ-025 Result: bits [2*DW-5:DW-4] plus round-half-up on bit DW-5; negative -> 0 (ReLU); positive overflow saturates to 2^(DW-1)-1.
REQ-026 CONV_WR (1 cycle): cwr=1, caddr_wr=pixel address, csel=1+c; 11 cycles per conv output.
REQ-027 mode=0: after last conv write -> IDLE; busy falls the cycle after that write.
REQ-028 mode=1: after conv, per channel, per 2x2 block raster: POOL_RD 4 cycles (crd=1, addresses (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1), csel=1+c), POOL_CMP 1 cycle, POOL_WR 1 cycle writing signed max to (r*IMG_W/2+c), csel=1+NUM_CH+c.
REQ-029 Equal values in max: any (results identical); write address width unchanged, upper bits zero.
REQ-030 ready, mode, kw, kb ignored while busy=1; new job needs ready in IDLE.
REQ-031 cwr and crd never high in same cycle; cwr low outside *_WR states.
REQ-032 Total busy cycles: 11*IMG_W^2*NUM_CH, plus 6*(IMG_W/2)^2*NUM_CH if mode=1.

Reset
REQ-033 reset forces IDLE and busy, cwr, crd, csel, iaddr, caddr_wr, caddr_rd, cdata_wr to 0 immediately.
REQ-034 reset mid-job aborts with no further writes; next job starts from pixel 0 on fresh ready.
REQ-035 ready high during reset is ignored; first sampling at first clock edge after release.

Verification
REQ-036 LOG_W=2,NUM_CH=1, all pixels 1.0, all weights 1.0, bias 0, mode=0 -> corner 4.0, edge 6.0, interior 9.0, csel=1, 176 busy cycles.
REQ-037 Bias -20.0, same image -> every output 0 (ReLU).
REQ-038 Pixels 7.0, weights 7.0, bias 0 -> outputs saturate to 0x7FFFF.
REQ-039 LOG_W=2,NUM_CH=2, mode=1, ramp image -> 4 pool writes per channel at csel 3/4 equal to block max of model.
REQ-040 Assert reset at cycle 50 of a job -> all outputs 0 same cycle, no cwr until new ready.
REQ-041 Toggle ready and kw during busy -> results match original sampled weights, no restart.

Source files
------------

// File: rtl/conv_engine.sv
// 3x3 multi-channel convolution engine with zero padding, ReLU/saturation and optional
// 2x2 max-pool read-back pass over the stored convolution results.
`timescale 1ns/1ps
module conv_engine #(
    parameter int unsigned LOG_W  = 6,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DW     = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ready,
    input  logic                   mode,
    input  logic [NUM_CH*9*DW-1:0] kw,
    input  logic [NUM_CH*DW-1:0]   kb,
    output logic                   busy,
    output logic [2*LOG_W-1:0]     iaddr,
    input  logic [DW-1:0]          idata,
    output logic                   cwr,
    output logic [2*LOG_W-1:0]     caddr_wr,
    output logic [DW-1:0]          cdata_wr,
    output logic                   crd,
    output logic [2*LOG_W-1:0]     caddr_rd,
    input  logic [DW-1:0]          cdata_rd,
    output logic [2:0]             csel
);

    localparam int unsigned AW = 2*DW + 4;
    localparam int unsigned XW = LOG_W + 2;
    localparam int unsigned PW = LOG_W - 1;
    localparam logic [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StConvRd  = 3'd1;
    localparam logic [2:0] StConvAcc = 3'd2;
    localparam logic [2:0] StConvWr  = 3'd3;
    localparam logic [2:0] StPoolRd  = 3'd4;
    localparam logic [2:0] StPoolCmp = 3'd5;
    localparam logic [2:0] StPoolWr  = 3'd6;

    logic [2:0]              state_q, state_d;
    logic [NUM_CH*9*DW-1:0]  kw_q;
    logic [NUM_CH*DW-1:0]    kb_q;
    logic                    mode_q;
    logic [LOG_W-1:0]        row_q, col_q;
    logic [1:0]              ch_q;
    logic [3:0]              tap_q;
    logic                    prev_valid_q;
    logic [AW-1:0]           acc_q;
    logic [2*LOG_W-1:0]      iaddr_q;
    logic [PW-1:0]           pr_q, pc_q;
    logic [1:0]              step_q;
    logic [DW-1:0]           max_q, cdata_q;

    // Power-of-two sized tables so the channel/tap counters index them without width games.
    logic [DW-1:0] w_arr [4][16];
    logic [DW-1:0] b_arr [4];

    for (genvar c = 0; c < 4; c++) begin : g_ch
        for (genvar t = 0; t < 16; t++) begin : g_tap
            if (c < NUM_CH && t < 9) begin : g_w
                assign w_arr[c][t] = kw_q[(c*9+t)*DW +: DW];
            end else begin : g_z
                assign w_arr[c][t] = '0;
            end
        end
        if (c < NUM_CH) begin : g_b
            assign b_arr[c] = kb_q[c*DW +: DW];
        end else begin : g_bz
            assign b_arr[c] = '0;
        end
    end

    logic [1:0]          dy, dx;
    logic [XW-1:0]       ty, tx;
    logic                tap_in;
    logic [DW-1:0]       w_sel, b_sel, bigger, result;
    logic [2*DW-1:0]     prod;
    logic [AW-1:0]       term, bias_ext, sum, acc_d;
    logic [DW+7:0]       rounded;
    logic                last_ch, pix_last, pool_last;
    logic                unused_sum;

    always_comb begin
        dy = (tap_q >= 4'd6) ? 2'd2 : (tap_q >= 4'd3) ? 2'd1 : 2'd0;
        dx = 2'(tap_q - 4'(3 * dy));
        ty = {2'b00, row_q} + XW'(dy) - XW'(1);
        tx = {2'b00, col_q} + XW'(dx) - XW'(1);
        tap_in = (ty[XW-1:LOG_W] == 2'b00) && (tx[XW-1:LOG_W] == 2'b00);

        // Product for the tap issued last cycle, whose pixel is on idata now.
        w_sel = w_arr[ch_q][tap_q - 4'd1];
        b_sel = b_arr[ch_q];
        prod  = {{DW{w_sel[DW-1]}}, w_sel} * {{DW{idata[DW-1]}}, idata};
        term  = prev_valid_q ? {{4{prod[2*DW-1]}}, prod} : '0;
        bias_ext = {{(DW+4){b_sel[DW-1]}}, b_sel} << (DW-4);
        acc_d = (tap_q == 4'd0) ? '0 : acc_q + term;
        sum   = acc_q + term + bias_ext;

        rounded = sum[AW-1:DW-4] + (DW+8)'(sum[DW-5]);
        if (sum[AW-1]) begin
            result = '0;
        end else if (rounded > {8'b0, MaxVal}) begin
            result = MaxVal;
        end else begin
            result = rounded[DW-1:0];
        end

        bigger = ($signed(cdata_rd) > $signed(max_q)) ? cdata_rd : max_q;

        last_ch   = (ch_q == 2'(NUM_CH - 1));
        pix_last  = (&row_q) && (&col_q);
        pool_last = (&pr_q) && (&pc_q);
    end

    assign unused_sum = ^sum[DW-6:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (ready) state_d = StConvRd;
            StConvRd:  if (tap_q == 4'd8) state_d = StConvAcc;
            StConvAcc: state_d = StConvWr;
            StConvWr: begin
                if (last_ch && pix_last) state_d = mode_q ? StPoolRd : StIdle;
                else                     state_d = StConvRd;
            end
            StPoolRd:  if (step_q == 2'd3) state_d = StPoolCmp;
            StPoolCmp: state_d = StPoolWr;
            StPoolWr:  state_d = (last_ch && pool_last) ? StIdle : StPoolRd;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        cwr      = (state_q == StConvWr) || (state_q == StPoolWr);
        crd      = (state_q == StPoolRd);
        iaddr    = (state_q == StConvRd && tap_in) ? {ty[LOG_W-1:0], tx[LOG_W-1:0]} : iaddr_q;
        caddr_wr = '0;
        if (state_q == StConvWr) caddr_wr = {row_q, col_q};
        if (state_q == StPoolWr) caddr_wr = {2'b00, pr_q, pc_q};
        caddr_rd = crd ? {pr_q, step_q[1], pc_q, step_q[0]} : '0;
        case (state_q)
            StIdle:   csel = 3'd0;
            StPoolWr: csel = 3'(1 + NUM_CH) + {1'b0, ch_q};
            default:  csel = 3'd1 + {1'b0, ch_q};
        endcase
        cdata_wr = cdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            kw_q <= '0;
            kb_q <= '0;
            mode_q <= 1'b0;
            row_q <= '0;
            col_q <= '0;
            ch_q <= '0;
            tap_q <= '0;
            prev_valid_q <= 1'b0;
            acc_q <= '0;
            iaddr_q <= '0;
            pr_q <= '0;
            pc_q <= '0;
            step_q <= '0;
            max_q <= '0;
            cdata_q <= '0;
        end else begin
            state_q <= state_d;
            iaddr_q <= iaddr;
            case (state_q)
                StIdle: begin
                    if (ready) begin
                        kw_q <= kw;
                        kb_q <= kb;
                        mode_q <= mode;
                        row_q <= '0;
                        col_q <= '0;
                        ch_q <= '0;
                        tap_q <= '0;
                        pr_q <= '0;
                        pc_q <= '0;
                        step_q <= '0;
                    end
                end
                StConvRd: begin
                    tap_q <= tap_q + 4'd1;
                    prev_valid_q <= tap_in;
                    acc_q <= acc_d;
                end
                StConvAcc: cdata_q <= result;
                StConvWr: begin
                    tap_q <= '0;
                    if (last_ch) begin
                        ch_q <= '0;
                        col_q <= col_q + LOG_W'(1);
                        if (&col_q) row_q <= row_q + LOG_W'(1);
                    end else begin
                        ch_q <= ch_q + 2'd1;
                    end
                end
                StPoolRd: begin
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd1) max_q <= cdata_rd;
                    else if (step_q != 2'd0) max_q <= bigger;
                end
                StPoolCmp: cdata_q <= bigger;
                StPoolWr: begin
                    pc_q <= pc_q + PW'(1);
                    if (&pc_q) pr_q <= pr_q + PW'(1);
                    if (pool_last) ch_q <= ch_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: table of full conv jobs plus pool, reset-abort and
// busy-time input disturbance sequences against small image/result memory models.
`timescale 1ns/1ps
module tb_conv_engine;

    localparam int LOG_W  = 2;
    localparam int NUM_CH = 2;
    localparam int DW     = 20;
    localparam int CONV_CYC = 11 * 16 * NUM_CH;
    localparam int POOL_CYC = 6 * 4 * NUM_CH;

    logic                   clk, reset, ready, mode;
    logic [NUM_CH*9*DW-1:0] kw;
    logic [NUM_CH*DW-1:0]   kb;
    logic                   busy, cwr, crd;
    logic [2*LOG_W-1:0]     iaddr, caddr_wr, caddr_rd;
    logic [DW-1:0]          idata, cdata_wr, cdata_rd;
    logic [2:0]             csel;

    conv_engine #(.LOG_W(LOG_W), .NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .ready(ready), .mode(mode), .kw(kw), .kb(kb),
        .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
        .csel(csel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] img [16];
    logic [DW-1:0] cmem [8][16];
    int            wr_cnt [8];
    logic          clr, overlap;

    always @(posedge clk) begin
        idata <= img[iaddr];
        if (crd) cdata_rd <= cmem[csel][caddr_rd];
        if (clr) begin
            for (int s = 0; s < 8; s++) begin
                wr_cnt[s] <= 0;
                for (int a = 0; a < 16; a++) cmem[s][a] <= '0;
            end
            overlap <= 1'b0;
        end else begin
            if (cwr) begin
                cmem[csel][caddr_wr] <= cdata_wr;
                wr_cnt[csel] <= wr_cnt[csel] + 1;
            end
            if (cwr && crd) overlap <= 1'b1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NUM_CH*9*DW-1:0] kern(input logic [DW-1:0] a,
                                                    input logic [DW-1:0] c,
                                                    input bit center_only);
        logic [NUM_CH*9*DW-1:0] k;
        k = '0;
        for (int t = 0; t < 9; t++) begin
            if (!center_only || t == 4) begin
                k[t*DW +: DW]     = a;
                k[(9+t)*DW +: DW] = c;
            end
        end
        return k;
    endfunction

    task automatic run_job(input logic [NUM_CH*9*DW-1:0] k, input logic [NUM_CH*DW-1:0] b,
                           input logic m, input bit disturb, output int cyc);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        kw = k; kb = b; mode = m; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        cyc = 0;
        while (busy && cyc < 2000) begin
            if (disturb && cyc == 20) begin
                ready = 1'b1; kw = ~k; kb = ~b; mode = ~m;
            end
            if (disturb && cyc == 40) ready = 1'b0;
            cyc++;
            @(posedge clk); #1;
        end
        ready = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] pix, w0, w1, b0, b1;
        logic [DW-1:0] e0c, e0e, e0i, e1c, e1e, e1i;
    } vec_t;

    vec_t vecs [4];
    int   cyc;
    logic [DW-1:0] exp_max;

    initial begin
        // unity/half kernels, bias ReLU, saturation both ways, rounding half-up
        vecs[0] = '{20'h08000, 20'h10000, 20'h08000, 20'h00000, 20'h00000,
                    20'h20000, 20'h30000, 20'h48000, 20'h10000, 20'h18000, 20'h24000};
        vecs[1] = '{20'h08000, 20'h08000, 20'h10000, 20'h80000, 20'hC8000,
                    20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h10000};
        vecs[2] = '{20'h70000, 20'h70000, 20'h90000, 20'h00000, 20'h00000,
                    20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h00000, 20'h00000, 20'h00000};
        vecs[3] = '{20'h00001, 20'h08000, 20'h04000, 20'h00000, 20'h00000,
                    20'h00002, 20'h00003, 20'h00005, 20'h00001, 20'h00002, 20'h00002};

        reset = 1'b1; ready = 1'b1; mode = 1'b0; kw = '0; kb = '0;
        clr = 1'b0; cdata_rd = '0; idata = '0;
        for (int i = 0; i < 16; i++) img[i] = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_cwr", cwr, 0);
        check("rst_crd", crd, 0);
        check("rst_csel", csel, 0);
        check("rst_iaddr", iaddr, 0);
        check("rst_cdata_wr", cdata_wr, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("ready_in_reset_ignored", busy, 0);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 16; i++) img[i] = vecs[v].pix;
            run_job(kern(vecs[v].w0, vecs[v].w1, 1'b0), {vecs[v].b1, vecs[v].b0}, 1'b0, 1'b0, cyc);
            check($sformatf("v%0d_busy_cycles", v), cyc, CONV_CYC);
            check($sformatf("v%0d_writes", v), wr_cnt[1] + wr_cnt[2], 32);
            check($sformatf("v%0d_ch0_corner", v), cmem[1][0], vecs[v].e0c);
            check($sformatf("v%0d_ch0_edge", v), cmem[1][1], vecs[v].e0e);
            check($sformatf("v%0d_ch0_interior", v), cmem[1][5], vecs[v].e0i);
            check($sformatf("v%0d_ch1_corner", v), cmem[2][15], vecs[v].e1c);
            check($sformatf("v%0d_ch1_edge", v), cmem[2][13], vecs[v].e1e);
            check($sformatf("v%0d_ch1_interior", v), cmem[2][10], vecs[v].e1i);
            check($sformatf("v%0d_idle_csel", v), csel, 0);
        end

        // Pool pass: identity (ch0) and x2 (ch1) kernels over a scrambled ramp.
        for (int i = 0; i < 16; i++) img[i] = DW'(((i * 7) % 16) * 'h4000);
        run_job(kern(20'h10000, 20'h20000, 1'b1), '0, 1'b1, 1'b0, cyc);
        check("pool_busy_cycles", cyc, CONV_CYC + POOL_CYC);
        check("pool_conv_ch1", cmem[2][6], img[6] << 1);
        check("pool_writes_ch0", wr_cnt[3], 4);
        check("pool_writes_ch1", wr_cnt[4], 4);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                exp_max = '0;
                for (int d = 0; d < 4; d++) begin
                    if (img[(2*r + d/2)*4 + 2*c + d%2] > exp_max)
                        exp_max = img[(2*r + d/2)*4 + 2*c + d%2];
                end
                check($sformatf("pool_ch0_blk%0d%0d", r, c), cmem[3][r*2+c], exp_max);
                check($sformatf("pool_ch1_blk%0d%0d", r, c), cmem[4][r*2+c], exp_max << 1);
            end
        end
        check("cwr_crd_overlap", overlap, 0);

        // Reset 50 cycles into a job: outputs drop at once and nothing more is written.
        for (int i = 0; i < 16; i++) img[i] = vecs[0].pix;
        kw = kern(vecs[0].w0, vecs[0].w1, 1'b0); kb = '0; mode = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b1; ready = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_cwr", cwr, 0);
        check("abort_csel", csel, 0);
        check("abort_iaddr", iaddr, 0);
        check("abort_caddr_wr", caddr_wr, 0);
        check("abort_cdata_wr", cdata_wr, 0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        reset = 1'b0; ready = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("abort_no_writes", wr_cnt[1] + wr_cnt[2], 0);
        check("abort_stays_idle", busy, 0);
        run_job(kern(vecs[0].w0, vecs[0].w1, 1'b0), '0, 1'b0, 1'b0, cyc);
        check("restart_busy_cycles", cyc, CONV_CYC);
        check("restart_ch0_corner", cmem[1][0], vecs[0].e0c);
        check("restart_ch1_interior", cmem[2][5], vecs[0].e1i);

        // ready/kw/kb/mode changes while busy must be ignored.
        run_job(kern(vecs[0].w0, vecs[0].w1, 1'b0), '0, 1'b0, 1'b1, cyc);
        check("disturb_busy_cycles", cyc, CONV_CYC);
        check("disturb_ch0_edge", cmem[1][4], vecs[0].e0e);
        check("disturb_ch0_interior", cmem[1][10], vecs[0].e0i);
        check("disturb_ch1_corner", cmem[2][3], vecs[0].e1c);
        check("disturb_no_pool", wr_cnt[3] + wr_cnt[4], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
